ex_wb_elastic_reg: RTL and testbench
====================================

Name: ex_wb_elastic_reg

Overview:
Parametrised, flow-controlled successor to the fixed EX->WB pipeline register. It carries the PC, RegWrite, result and destination register from Execute to Write-Back.
- Adds valid/ready handshaking, a two-entry skid buffer so that in_ready is a registered signal, and a synchronous flush.
- Sits between the EX stage and the register-file write port. Bubbles never produce a register-file write.

Parameters:
PC_W, 8, PC field width
DATA_W, 8, result field width
REG_ADDR_W, 3, destination register index width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
flush  in  1  synchronous flush; drops all held and incoming beats
in_valid  in  1  EX beat present
in_ready  out  1  stage can accept a beat (registered)
pc_ex  in  PC_W  PC of EX instruction
reg_write_ex  in  1  EX write enable
result_ex  in  DATA_W  EX result
write_reg_ex  in  REG_ADDR_W  EX destination register
out_valid  out  1  WB beat present
out_ready  in  1  WB consumes the beat
pc_wb  out  PC_W  PC of WB beat
reg_write_wb  out  1  stored RegWrite AND out_valid
result_wb  out  DATA_W  WB result
write_reg_wb  out  REG_ADDR_W  WB destination register

Behaviour:
- Handshakes:
  - Accept when in_valid && in_ready.
  - Deliver when out_valid && out_ready.
  - Payload = {pc, reg_write, result, write_reg}, moved as one unit.
- Storage: main entry (drives the outputs) and skid entry. State is one of EMPTY, ONE, FULL.
- Derived signals: out_valid = (state != EMPTY); in_ready = (state != FULL). Both are decoded from registered state only.
- Latency: 1 cycle from accept to out_valid when the stage is not blocked. Throughput is 1 beat/cycle while out_ready stays high.
- Transitions (no flush):
  - EMPTY: accept -> ONE, main <= input. Otherwise stay.
  - ONE, out_ready && accept -> ONE, main <= input.
  - ONE, out_ready && !accept -> EMPTY.
  - ONE, !out_ready && accept -> FULL, skid <= input.
  - ONE, !out_ready && !accept -> ONE, hold.
  - FULL, out_ready -> ONE, main <= skid. No accept is possible because in_ready=0.
  - FULL, !out_ready -> FULL, hold.
- Flush:
  - Next state is EMPTY from any state.
  - Overrides accept and deliver in the same cycle; the incoming beat is dropped.
  - Payload registers may hold stale data, but reg_write_wb=0 because it is gated by out_valid.
- Reset (async assert, sync-released by the system):
  - state=EMPTY, all payload registers 0.
  - Therefore out_valid=0, in_ready=1, pc_wb=0, reg_write_wb=0, result_wb=0, write_reg_wb=0.
  - Reset mid-transfer discards everything.
- Bubbles: while EMPTY, outputs show the last main contents with reg_write_wb forced to 0.
- Ordering: strict FIFO; the skid beat is always older than any later accept.
- No arithmetic; widths are pass-through exactly as parametrised.

Optional Feature:
STALL_CNT_EN
- Defined: adds output stall_cnt [15:0].
  - Increments every cycle with out_valid && !out_ready.
  - Saturates at 16'hFFFF; no wrap.
  - Cleared by reset only; flush does not clear it.
- Undefined: no port and no counter logic.

Decomposition:
- Shared package pipe_pkg holds:
  - default width constants PC_W_DEF=8, DATA_W_DEF=8, REG_ADDR_W_DEF=3;
  - state enum {EMPTY=2'd0, ONE=2'd1, FULL=2'd2};
  - STALL_CNT_W=16.
- Sub-module pipe_payload_reg: load-enabled register of width PC_W+1+DATA_W+REG_ADDR_W with async active-low reset to zero. Instantiated twice, once for main and once for skid.

Test Plan:
- Reset: reset=0 mid-stream with FULL state -> immediately out_valid=0, in_ready=1, all outputs 0.
- Streaming: out_ready=1, feed PCs 0x10,0x11,0x12 on consecutive cycles with in_valid=1 -> pc_wb 0x10,0x11,0x12 on the following three cycles; in_ready stays 1.
- Back-pressure: out_ready=0, send A(pc 0x20, res 0x5A, reg 3), then B(pc 0x21) -> state FULL and in_ready=0 after B. Raise out_ready -> A delivered, then B delivered, no loss or duplication.
- Flush priority: state FULL with in_valid=1 and flush=1 -> next cycle out_valid=0, reg_write_wb=0, in_ready=1; the dropped beat never appears.
- Bubble gating: beat with reg_write_ex=1 delivered, then no input -> reg_write_wb=0 while write_reg_wb and result_wb hold their old values.
- STALL_CNT_EN: hold out_valid=1, out_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF and holds there. Without the macro, the port is absent (elaboration check).

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared widths, state encoding and counter width for the EX->WB elastic pipeline register.
package pipe_pkg;

  localparam int unsigned PC_W_DEF       = 8;
  localparam int unsigned DATA_W_DEF     = 8;
  localparam int unsigned REG_ADDR_W_DEF = 3;
  localparam int unsigned STALL_CNT_W    = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_payload_reg.sv
// Load-enabled payload register with asynchronous active-low reset to zero.
module pipe_payload_reg #(
  parameter int unsigned WIDTH = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ex_wb_elastic_reg.sv
// Flow-controlled EX->WB pipeline register with a two-entry skid buffer and synchronous flush.
// Optional macro STALL_CNT_EN adds a saturating output-stall counter port stall_cnt.
module ex_wb_elastic_reg
  import pipe_pkg::*;
#(
  parameter int unsigned PC_W       = PC_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PC_W-1:0]       pc_ex,
  input  logic                  reg_write_ex,
  input  logic [DATA_W-1:0]     result_ex,
  input  logic [REG_ADDR_W-1:0] write_reg_ex,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PC_W-1:0]       pc_wb,
  output logic                  reg_write_wb,
  output logic [DATA_W-1:0]     result_wb,
  output logic [REG_ADDR_W-1:0] write_reg_wb
`ifdef STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  localparam int unsigned PAY_W = PC_W + 1 + DATA_W + REG_ADDR_W;

  pipe_state_e      state, state_next;
  logic             accept;
  logic             load_main, load_skid;
  logic [PAY_W-1:0] in_payload, main_d, main_q, skid_q;
  logic             main_reg_write;

  assign in_payload = {pc_ex, reg_write_ex, result_ex, write_reg_ex};
  assign out_valid  = (state != EMPTY);
  assign in_ready   = (state != FULL);
  assign accept     = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load_main  = 1'b0;
    load_skid  = 1'b0;
    main_d     = in_payload;
    if (flush) begin
      // Flush wins over both handshakes; payload may go stale, out_valid gates it.
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_next = ONE;
            load_main  = 1'b1;
          end
        end
        ONE: begin
          if (out_ready && accept) begin
            load_main = 1'b1;
          end else if (out_ready) begin
            state_next = EMPTY;
          end else if (accept) begin
            state_next = FULL;
            load_skid  = 1'b1;
          end
        end
        FULL: begin
          if (out_ready) begin
            state_next = ONE;
            load_main  = 1'b1;
            main_d     = skid_q;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  pipe_payload_reg #(.WIDTH(PAY_W)) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (load_main),
    .d     (main_d),
    .q     (main_q)
  );

  pipe_payload_reg #(.WIDTH(PAY_W)) u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (load_skid),
    .d     (in_payload),
    .q     (skid_q)
  );

  assign {pc_wb, main_reg_write, result_wb, write_reg_wb} = main_q;
  assign reg_write_wb = main_reg_write && out_valid;

`ifdef STALL_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_ex_wb_elastic_reg.sv
// Directed self-checking bench for ex_wb_elastic_reg; define STALL_CNT_EN to also exercise stall_cnt.
module tb_ex_wb_elastic_reg;
  import pipe_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] pc_ex = '0;
  logic       reg_write_ex = 1'b0;
  logic [7:0] result_ex = '0;
  logic [2:0] write_reg_ex = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] pc_wb;
  logic       reg_write_wb;
  logic [7:0] result_wb;
  logic [2:0] write_reg_wb;
`ifdef STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  ex_wb_elastic_reg #(.PC_W(8), .DATA_W(8), .REG_ADDR_W(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .pc_ex        (pc_ex),
    .reg_write_ex (reg_write_ex),
    .result_ex    (result_ex),
    .write_reg_ex (write_reg_ex),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .pc_wb        (pc_wb),
    .reg_write_wb (reg_write_wb),
    .result_wb    (result_wb),
    .write_reg_wb (write_reg_wb)
`ifdef STALL_CNT_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] pc, input logic rw,
                       input logic [7:0] res, input logic [2:0] wr);
    in_valid     = v;
    pc_ex        = pc;
    reg_write_ex = rw;
    result_ex    = res;
    write_reg_ex = wr;
  endtask

  initial begin
    #1;
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_pc_wb", {24'd0, pc_wb}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Streaming at full rate
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h10 + 8'(i), 1'b1, 8'h50 + 8'(i), 3'(i));
      step();
      check_eq("stream_valid", {31'd0, out_valid}, 32'd1);
      check_eq("stream_pc", {24'd0, pc_wb}, 32'h10 + 32'(i));
      check_eq("stream_in_ready", {31'd0, in_ready}, 32'd1);
    end
    check_eq("stream_rw", {31'd0, reg_write_wb}, 32'd1);

    // Bubble: last beat leaves, outputs hold with reg_write gated
    drive(1'b0, 8'h00, 1'b0, 8'h00, 3'd0);
    step();
    check_eq("bubble_valid", {31'd0, out_valid}, 32'd0);
    check_eq("bubble_rw", {31'd0, reg_write_wb}, 32'd0);
    check_eq("bubble_result", {24'd0, result_wb}, 32'h52);
    check_eq("bubble_wreg", {29'd0, write_reg_wb}, 32'd2);

    // Back-pressure: A then B fill the stage
    out_ready = 1'b0;
    drive(1'b1, 8'h20, 1'b1, 8'h5A, 3'd3);
    step();
    check_eq("bp_A_pc", {24'd0, pc_wb}, 32'h20);
    check_eq("bp_one_ready", {31'd0, in_ready}, 32'd1);
    drive(1'b1, 8'h21, 1'b0, 8'hA5, 3'd5);
    step();
    check_eq("bp_full_ready", {31'd0, in_ready}, 32'd0);
    check_eq("bp_full_pc", {24'd0, pc_wb}, 32'h20);
    check_eq("bp_full_res", {24'd0, result_wb}, 32'h5A);
    check_eq("bp_full_wreg", {29'd0, write_reg_wb}, 32'd3);
    drive(1'b1, 8'h22, 1'b1, 8'h77, 3'd7);
    step();
    check_eq("bp_hold_pc", {24'd0, pc_wb}, 32'h20);
    drive(1'b0, 8'h00, 1'b0, 8'h00, 3'd0);
    out_ready = 1'b1;
    step();
    check_eq("bp_B_pc", {24'd0, pc_wb}, 32'h21);
    check_eq("bp_B_res", {24'd0, result_wb}, 32'hA5);
    check_eq("bp_B_rw", {31'd0, reg_write_wb}, 32'd0);
    check_eq("bp_B_ready", {31'd0, in_ready}, 32'd1);
    step();
    check_eq("bp_drained", {31'd0, out_valid}, 32'd0);

    // Flush while FULL with a beat arriving
    out_ready = 1'b0;
    drive(1'b1, 8'h30, 1'b1, 8'h11, 3'd1);
    step();
    drive(1'b1, 8'h31, 1'b1, 8'h12, 3'd2);
    step();
    check_eq("fl_full_ready", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 8'h32, 1'b1, 8'h13, 3'd3);
    flush = 1'b1;
    step();
    check_eq("fl_valid", {31'd0, out_valid}, 32'd0);
    check_eq("fl_rw", {31'd0, reg_write_wb}, 32'd0);
    check_eq("fl_ready", {31'd0, in_ready}, 32'd1);
    flush = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 8'h00, 3'd0);
    out_ready = 1'b1;
    step();
    check_eq("fl_no_ghost", {31'd0, out_valid}, 32'd0);
    drive(1'b1, 8'h40, 1'b1, 8'h44, 3'd4);
    step();
    check_eq("fl_next_pc", {24'd0, pc_wb}, 32'h40);
    check_eq("fl_next_rw", {31'd0, reg_write_wb}, 32'd1);

    // Asynchronous reset while FULL
    out_ready = 1'b0;
    drive(1'b1, 8'h50, 1'b1, 8'h66, 3'd6);
    step();
    drive(1'b1, 8'h51, 1'b1, 8'h67, 3'd7);
    step();
    check_eq("rs_full_ready", {31'd0, in_ready}, 32'd0);
    #2;
    reset = 1'b0;
    #1;
    check_eq("rs_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rs_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rs_outs", {12'd0, pc_wb, reg_write_wb, result_wb, write_reg_wb}, 32'd0);
    drive(1'b0, 8'h00, 1'b0, 8'h00, 3'd0);
    @(negedge clk);
    reset = 1'b1;

`ifdef STALL_CNT_EN
    check_eq("sc_reset", {16'd0, stall_cnt}, 32'd0);
    drive(1'b1, 8'h60, 1'b1, 8'h01, 3'd1);
    step();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 3'd0);
    check_eq("sc_start", {16'd0, stall_cnt}, 32'd0);
    repeat (10) step();
    check_eq("sc_ten", {16'd0, stall_cnt}, 32'd10);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("sc_flush_keep", {16'd0, stall_cnt}, 32'd11);
    drive(1'b1, 8'h61, 1'b1, 8'h02, 3'd2);
    step();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 3'd0);
    repeat (70000) step();
    check_eq("sc_sat", {16'd0, stall_cnt}, 32'hFFFF);
    repeat (5) step();
    check_eq("sc_hold", {16'd0, stall_cnt}, 32'hFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
